uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Serial transmit engine of the UART. It accepts one character per `load` strobe from the processor-side write decode, builds the frame (start, data LSB-first, optional parity, stop), and shifts it onto `tx` one bit per `btu` pulse. It sits directly upstream of the bit time counter: it drives that counter's `doit` enable and consumes its `btu` pulse as the bit-advance strobe.

## Interface
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 or 2.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `load`  in  1  one-cycle write strobe; honoured only while `tx_ready`=1.
- `data_in`  in  8  character to send; sampled on an accepted `load`.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits (`data_in[7]` ignored).
- `pen`  in  1  parity enable; sampled on an accepted `load`.
- `ohel`  in  1  parity sense, 1 = odd, 0 = even; sampled on an accepted `load`.
- `btu`  in  1  bit-time-up pulse from the bit time counter.
- `doit`  out  1  enable to the bit time counter; high for the whole frame.
- `tx`  out  1  serial line, idle high.
- `tx_ready`  out  1  high when idle and able to accept `load`.
- `tx_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- All outputs are registered. Reset values: `tx`=1, `doit`=0, `tx_ready`=1, `tx_done`=0, state IDLE, bit count 0.
- States: IDLE and SEND.
- IDLE -> SEND on `load`=1. On that edge: latch `data_in`, `eight`, `pen`, and `ohel` into an 11-bit frame shift register; set `tx`=0 (start bit), `doit`=1, `tx_ready`=0; clear the bit count.
- Frame order: start(0), then `data[0]`..`data[6]`, then `data[7]` if `eight`. Next comes the parity bit if `pen`, then `STOP_BITS` ones.
- Frame length N = 1 + (7 or 8) + `pen` + `STOP_BITS`, giving a range of 9..12 bits.
- Parity bit = XOR of the transmitted data bits XOR `ohel`. Even parity makes the total count of ones even; odd parity makes it odd.
- In SEND, each `btu`=1 edge increments the bit count and shifts the next frame bit onto `tx`.
- On the edge where `btu`=1 and the bit count equals N-1 (the last bit is ending), go to IDLE:
  - set `tx`=1, `doit`=0, `tx_ready`=1;
  - pulse `tx_done`=1 for exactly one cycle.
- `btu` is ignored in IDLE.
- `load` is ignored in SEND, including on the final-bit edge. A `load` on that edge is dropped; software must wait for `tx_ready`.
- Mode inputs (`eight`, `pen`, `ohel`) changing mid-frame have no effect on the frame in progress.

## Timing
- Load latency: `tx` falls and `doit` rises on the same edge that samples `load`, i.e. they are visible the cycle after the strobe.
- Each bit is held on `tx` from one accepted `btu` edge to the next. With the bit time counter, that is `bit_period`+1 clocks per bit.
- The frame occupies N×(`bit_period`+1) clocks from the load edge to the edge that raises `tx_ready`.
- Back-to-back operation: a `load` in the first cycle with `tx_ready`=1 starts the next frame. The minimum idle gap on `tx` is therefore 1 clock beyond the stop bits.
- Reset asserted mid-frame forces `tx`=1, `doit`=0, and `tx_ready`=1 asynchronously. The partial frame is abandoned and no `tx_done` is issued.
- `load` and `reset` asserted together: reset wins.

## Test plan
- Reset, then `load` with `data_in`=8'h55, `eight`=1, `pen`=0, `bit_period`=4. Required: `tx` = 0,1,0,1,0,1,0,1,0,1. Each level is held 5 clocks; 10 bits total; `tx_done` pulses once; `doit` is high 50 clocks.
- `data_in`=8'hA3, `eight`=0, `pen`=1, `ohel`=0. Required: 7 data bits 1,1,0,0,0,1,0, then parity 1 (three ones, even), then stop; N=10.
- Same data with `ohel`=1. Required: parity bit 0. With `STOP_BITS`=2, `eight`=1, `pen`=1, N=12 and the final two bits are 1,1.
- Issue `load` with `data_in`=8'hFF during SEND, and again on the final-bit edge. Required: both are ignored; the current frame is unchanged; no second frame starts.
- Assert `reset` asynchronously during data bit 3. Required: `tx`=1, `doit`=0, `tx_ready`=1 before the next clock edge; no `tx_done` pulse.
- Issue back-to-back loads of 8'h00 and 8'hFF, the second in the first `tx_ready` cycle. Required: two correct frames separated by exactly 1 idle clock; two `tx_done` pulses.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames one character (start, 7/8 data LSB-first, optional parity, stop bits)
// and shifts it onto tx, advancing one bit per btu pulse from the bit time counter.
//
// state | meaning
// IDLE  | line high, tx_ready=1, waiting for load
// SEND  | frame in progress, doit=1, one bit per btu
module uart_tx_engine #(
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_in,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       btu,
    output logic       doit,
    output logic       tx,
    output logic       tx_ready,
    output logic       tx_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0] STOP_W = (STOP_BITS == 2) ? 4'd2 : 4'd1;

    state_t      state_q, state_d;
    logic [10:0] shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  last_q, last_d;
    logic        tx_q, tx_d;
    logic        doit_q, doit_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;

    logic [7:0]  data_eff;
    logic        parity;
    logic [10:0] payload;
    logic [3:0]  last_calc;

    // Bits following the start bit; upper positions are filled with ones so stop bits fall out naturally.
    always_comb begin
        data_eff  = {eight & data_in[7], data_in[6:0]};
        parity    = (^data_eff) ^ ohel;
        last_calc = 4'd7 + {3'b000, eight} + {3'b000, pen} + STOP_W;
        payload   = 11'h7ff;
        case ({eight, pen})
            2'b11:   payload = {2'b11, parity, data_eff};
            2'b10:   payload = {3'b111, data_eff};
            2'b01:   payload = {3'b111, parity, data_eff[6:0]};
            default: payload = {4'b1111, data_eff[6:0]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        tx_d      = tx_q;
        doit_d    = doit_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = SEND;
                    shift_d   = payload;
                    bit_cnt_d = 4'd0;
                    last_d    = last_calc;
                    tx_d      = 1'b0;
                    doit_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            SEND: begin
                if (btu) begin
                    if (bit_cnt_q == last_q) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        doit_d  = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b1, shift_q[10:1]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= 11'h7ff;
            bit_cnt_q <= 4'd0;
            last_q    <= 4'd0;
            tx_q      <= 1'b1;
            doit_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            tx_q      <= tx_d;
            doit_q    <= doit_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign tx       = tx_q;
    assign doit     = doit_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: bit time counter model (bit_period=4), frame scoreboard and directed scenarios.
module tb_uart_tx_engine;

    localparam int BP = 4;
    localparam int BT = BP + 1;

    typedef struct {
        logic [11:0] bits;
        int          n;
    } frame_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0, load2 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       eight = 1'b1, pen = 1'b0, ohel = 1'b0;
    logic       btu, btu2;
    logic       doit, tx, tx_ready, tx_done;
    logic       doit2, tx2, tx_ready2, tx_done2;
    int         cnt1, cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    frame_t      exp_q[$];
    logic        samples[$];
    int          done_cnt = 0;
    logic [11:0] last_bits = '0;
    int          last_len = 0;
    int          idle_run = 0;
    int          last_gap = 0;
    int          idle_bad = 0;
    int          ready_bad = 0;

    uart_tx_engine #(.STOP_BITS(1)) dut (
        .clock(clock), .reset(reset), .load(load), .data_in(data_in), .eight(eight),
        .pen(pen), .ohel(ohel), .btu(btu), .doit(doit), .tx(tx), .tx_ready(tx_ready),
        .tx_done(tx_done)
    );

    uart_tx_engine #(.STOP_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .load(load2), .data_in(data_in), .eight(eight),
        .pen(pen), .ohel(ohel), .btu(btu2), .doit(doit2), .tx(tx2), .tx_ready(tx_ready2),
        .tx_done(tx_done2)
    );

    always #5 clock = ~clock;

    // Bit time counter model: btu every BP+1 clocks while doit is high.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt1 <= 0;
            cnt2 <= 0;
        end else begin
            cnt1 <= (!doit || cnt1 == BP) ? 0 : cnt1 + 1;
            cnt2 <= (!doit2 || cnt2 == BP) ? 0 : cnt2 + 1;
        end
    end
    assign btu  = doit && (cnt1 == BP);
    assign btu2 = doit2 && (cnt2 == BP);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic frame_t build(input logic [7:0] d, input logic e, input logic p,
                                     input logic o, input int stops);
        frame_t f;
        int     k;
        logic   ones;
        f.bits = '0;
        k = 1;
        ones = 1'b0;
        for (int i = 0; i < (e ? 8 : 7); i++) begin
            f.bits[k] = d[i];
            ones ^= d[i];
            k++;
        end
        if (p) begin
            f.bits[k] = ones ^ o;
            k++;
        end
        for (int i = 0; i < stops; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n = k;
        return f;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            samples.delete();
        end else begin
            if (!doit && tx !== 1'b1) idle_bad++;
            if (doit === tx_ready) ready_bad++;
            if (doit) begin
                samples.push_back(tx);
                if (idle_run > 0) last_gap = idle_run;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (tx_done) begin
                frame_t e;
                int     errs;
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    errs = 0;
                    last_bits = '0;
                    for (int i = 0; i < samples.size(); i++)
                        if (i / BT < e.n && samples[i] !== e.bits[i / BT]) errs++;
                    for (int i = 0; i < e.n; i++)
                        if (i * BT + 2 < samples.size()) last_bits[i] = samples[i * BT + 2];
                    last_len = samples.size();
                    chk("frame_len", samples.size(), e.n * BT);
                    chk("frame_bits", errs, 0);
                end
                samples.delete();
            end
        end
    end

    task automatic do_load(input logic [7:0] d, input logic e, input logic p, input logic o);
        @(negedge clock);
        load = 1'b1;
        data_in = d;
        eight = e;
        pen = p;
        ohel = o;
        if (tx_ready) exp_q.push_back(build(d, e, p, o, 1));
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!tx_done && c < budget);
        if (!tx_done) chk("done_timeout", tx_done, 1);
    endtask

    initial begin
        int          base;
        logic        s2[$];
        logic [11:0] bits2;
        int          errs2;
        frame_t      e2;

        repeat (2) @(negedge clock);
        chk("rst_tx", tx, 1);
        chk("rst_doit", doit, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", tx_done, 0);
        reset = 1'b0;
        @(negedge clock);

        // 0x55, 8N1
        do_load(8'h55, 1, 0, 0);
        chk("load_tx_low", tx, 0);
        chk("load_doit", doit, 1);
        wait_done(200);
        @(negedge clock);
        chk("f55_bits", last_bits, 12'h2AA);
        chk("f55_doit_clks", last_len, 50);
        chk("f55_done_cnt", done_cnt, 1);

        // 0xA3, 7 bits, even parity; mode inputs changed mid-frame
        do_load(8'hA3, 0, 1, 0);
        eight = 1'b1; pen = 1'b0; ohel = 1'b1;
        wait_done(200);
        @(negedge clock);
        chk("fA3_even_bits", last_bits, 12'h346);

        // odd parity
        do_load(8'hA3, 0, 1, 1);
        eight = 1'b0; pen = 1'b0; ohel = 1'b0;
        wait_done(200);
        @(negedge clock);
        chk("fA3_odd_bits", last_bits, 12'h246);

        // loads during SEND and on the final-bit edge are dropped
        base = done_cnt;
        do_load(8'h3C, 1, 0, 0);
        repeat (10) @(negedge clock);
        load = 1'b1; data_in = 8'hFF;
        @(negedge clock);
        load = 1'b0;
        repeat (38) @(negedge clock);
        load = 1'b1; data_in = 8'hFF;
        @(negedge clock);
        load = 1'b0;
        chk("final_edge_ready", tx_ready, 1);
        chk("final_edge_doit", doit, 0);
        repeat (3) @(negedge clock);
        chk("dropped_no_restart", doit, 0);
        repeat (60) @(negedge clock);
        chk("dropped_done_cnt", done_cnt - base, 1);
        chk("f3C_bits", last_bits, 12'h278);

        // async reset during data bit 3
        base = done_cnt;
        do_load(8'h5A, 1, 0, 0);
        repeat (22) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_doit", doit, 0);
        chk("arst_ready", tx_ready, 1);
        exp_q.delete();
        @(negedge clock);
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_beats_load", doit, 0);
        repeat (60) @(negedge clock);
        chk("arst_no_done", done_cnt - base, 0);

        // back-to-back 0x00 then 0xFF
        base = done_cnt;
        do_load(8'h00, 1, 0, 0);
        wait_done(200);
        load = 1'b1;
        data_in = 8'hFF;
        if (tx_ready) exp_q.push_back(build(8'hFF, 1, 0, 0, 1));
        @(negedge clock);
        load = 1'b0;
        chk("b2b_first_bits", last_bits, 12'h200);
        wait_done(200);
        @(negedge clock);
        chk("b2b_second_bits", last_bits, 12'h3FE);
        chk("b2b_gap", last_gap, 1);
        chk("b2b_done_cnt", done_cnt - base, 2);

        // two stop bits, 8 data, even parity on the second engine
        @(negedge clock);
        load2 = 1'b1; data_in = 8'hA3; eight = 1'b1; pen = 1'b1; ohel = 1'b0;
        @(negedge clock);
        load2 = 1'b0;
        for (int i = 0; i < 12 * BT; i++) begin
            s2.push_back(tx2);
            if (!doit2) chk("sb2_doit_hold", doit2, 1);
            @(negedge clock);
        end
        chk("sb2_done", tx_done2, 1);
        chk("sb2_ready", tx_ready2, 1);
        bits2 = '0;
        errs2 = 0;
        for (int i = 0; i < 12; i++) bits2[i] = s2[i * BT + 2];
        for (int i = 0; i < 12 * BT; i++) if (s2[i] !== s2[(i / BT) * BT]) errs2++;
        e2 = build(8'hA3, 1, 1, 0, 2);
        chk("sb2_bits_model", bits2, e2.bits);
        chk("sb2_bits_const", bits2, 12'hD46);
        chk("sb2_stop", bits2[11:10], 2'b11);
        chk("sb2_hold", errs2, 0);
        @(negedge clock);
        chk("sb2_done_pulse", tx_done2, 0);

        chk("idle_line_high", idle_bad, 0);
        chk("ready_vs_doit", ready_bad, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
